mt_ckpt_rename: RTL and testbench
=================================

// Module: mt_ckpt_rename
// PURPOSE
//  Parametrised N-wide register rename map table with branch checkpoints. Sits between decode/free list
//  and RS/ROB: renames DISP_W instructions per cycle, tracks per-PR readiness from CDB_W broadcasts,
//  keeps a retirement map (RRAT) for full-flush recovery, and NUM_CKPT map snapshots for 1-cycle
//  branch-mispredict recovery.
// PARAMETERS
//  DISP_W    2    instructions renamed per cycle
//  CDB_W     6    CDB broadcast lanes
//  RET_W     2    retire lanes into RRAT
//  NUM_AR    32   architectural registers (AR_W=$clog2)
//  NUM_PR    128  physical registers (PR_W=$clog2)
//  NUM_CKPT  4    branch checkpoints (CK_W=$clog2)
// PORTS
//  clock          in  1            rising-edge clock
//  reset          in  1            asynchronous, active-high
//  disp_valid     in  DISP_W       slot k renames this cycle
//  disp_dest_ar   in  DISP_W*AR_W  dest AR per slot
//  disp_dest_pr   in  DISP_W*PR_W  new PR from free list per slot
//  disp_src_a_ar  in  DISP_W*AR_W  source A AR per slot
//  disp_src_b_ar  in  DISP_W*AR_W  source B AR per slot
//  rs_src_a_pr    out DISP_W*PR_W  renamed source A
//  rs_src_a_rdy   out DISP_W       source A value available
//  rs_src_b_pr    out DISP_W*PR_W  renamed source B
//  rs_src_b_rdy   out DISP_W       source B value available
//  rob_told       out DISP_W*PR_W  previous mapping of dest AR (freed at retire)
//  cdb_valid      in  CDB_W        lane valid
//  cdb_pr_tag     in  CDB_W*PR_W   completing PR
//  ret_valid      in  RET_W        retire lane valid, lane 0 oldest
//  ret_ar         in  RET_W*AR_W   retiring dest AR
//  ret_pr         in  RET_W*PR_W   retiring dest PR
//  recover        in  1            full flush: map <= RRAT
//  ckpt_take      in  1            snapshot map after this cycle's dispatch group
//  ckpt_id        out CK_W         id given to ckpt_take this cycle (= tail pointer)
//  ckpt_full      out 1            no free checkpoint; decode must stall branches
//  br_valid       in  1            branch resolved
//  br_mispredict  in  1            qualifies br_valid
//  br_id          in  CK_W         checkpoint of resolved branch
// BEHAVIOUR
//  - Reset (async): map[i]=i, rrat[i]=i, rdy[NUM_PR-1:0]=all 1, ckpt head=tail=count=0, all done bits 0.
//    Outputs are combinational from state; after reset rs_*_pr=src AR, rs_*_rdy=1, rob_told=dest AR, ckpt_full=0.
//  - Rename is combinational, same cycle. Slot j src: youngest valid slot k<j with dest_ar==src -> disp_dest_pr[k],
//    rdy=0; else map[src], rdy=rdy[pr] | (any cdb_valid lane tag==pr) (same-cycle CDB bypass).
//  - rob_told[j]: youngest valid k<j with same dest_ar -> disp_dest_pr[k]; else map[dest_ar[j]].
//  - Map write at edge: for each dest AR, youngest valid slot wins. rdy[dest_pr]<=0 for valid slots.
//  - Ready is PR-indexed: CDB sets rdy[tag]<=1 per valid lane; dispatch clear wins over CDB set on same PR.
//    Ready is never restored from checkpoints (reallocation re-clears it).
//  - Retire: rrat[ret_ar[l]]<=ret_pr[l]; higher lane wins on same AR.
//  - Checkpoints: circular FIFO. ckpt_take with !ckpt_full: snap[tail]<=post-dispatch map, done[tail]<=0,
//    tail++, count++. ckpt_take while ckpt_full is ignored (protocol error, assertion).
//    Correct resolve: done[br_id]<=1; head advances over one done entry per cycle, clearing it, count--.
//    Mispredict: map<=snap[br_id] next cycle; tail<=br_id+1 (wraps), frees all younger; same-cycle dispatch,
//    ckpt_take and correct resolves are discarded; count recomputed from head/tail.
//  - Priority: recover > mispredict > dispatch/ckpt_take. recover: map<=rrat (same-cycle retires applied to
//    both rrat and restored map), rdy<=all 1, ckpt head=tail=count=0, done cleared; retire still updates RRAT.
//  - Pointer wrap modulo NUM_CKPT; count 0..NUM_CKPT, ckpt_full=(count==NUM_CKPT).
// CONFIGURATION
//  MT_ZERO_REG_EN defined: AR NUM_AR-1 is hard zero: dest writes to it never change map/rrat/rdy,
//   rob_told returns that slot's own disp_dest_pr (freed at retire); sources reading it give rdy=1,
//   and are excluded from intra-group bypass. Undefined: AR NUM_AR-1 renamed like any other.
// STRUCTURE
//  - mt_pkg: width localparams (AR_W, PR_W, CK_W), ZERO_AR constant, ckpt_id_t typedef.
//  - Sub-module mt_ckpt_ctrl: head/tail/count/done bookkeeping, ckpt_id/ckpt_full;
//    snapshot storage and map muxing stay in top.
// TESTING
//  1 Reset mid-run -> next cycle src AR 5 gives pr 5 rdy 1; ckpt_full=0; rob_told(dest 7)=7.
//  2 Slot0 dest r3->pr40, slot1 src_a r3, dest r3->pr41 -> slot1 src_a=40 rdy0, told1=40; next map[3]=41.
//  3 rdy[40]=0, cdb tag 40 same cycle as read -> rdy1; next cycle rdy[40]=1.
//  4 Take 4 ckpts -> ids 0..3, ckpt_full=1; resolve id0 correct -> ckpt_full=0 next-next cycle.
//  5 Ckpt id1 after r3->pr50, then r3->pr60, mispredict id1 -> map[3]=50, ckpt_id=2, younger freed.
//  6 recover with retire r3->pr50 same cycle -> map[3]=50, all rdy 1, count 0; MT_ZERO_REG_EN: dest r31 no-op.

Source files
------------

// File: rtl/mt_ckpt_rename_pkg.sv
// Shared widths, checkpoint types and helpers for the checkpointed rename map.
// MT_ZERO_REG_EN: when defined, AR NUM_AR-1 is a hard-wired zero register.
package mt_pkg;
    localparam int unsigned NUM_AR   = 32;
    localparam int unsigned NUM_PR   = 128;
    localparam int unsigned NUM_CKPT = 4;
    localparam int unsigned AR_W     = $clog2(NUM_AR);
    localparam int unsigned PR_W     = $clog2(NUM_PR);
    localparam int unsigned CK_W     = $clog2(NUM_CKPT);

    localparam logic [AR_W-1:0] ZERO_AR = AR_W'(NUM_AR - 1);

`ifdef MT_ZERO_REG_EN
    localparam bit ZERO_REG_EN = 1'b1;
`else
    localparam bit ZERO_REG_EN = 1'b0;
`endif

    typedef logic [CK_W-1:0] ckpt_id_t;
    typedef logic [CK_W:0]   ckpt_cnt_t;

    function automatic ckpt_id_t ckpt_inc(ckpt_id_t p);
        return (p == ckpt_id_t'(NUM_CKPT - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic is_zero_ar(logic [AR_W-1:0] ar);
        return ZERO_REG_EN && (ar == ZERO_AR);
    endfunction
endpackage

// File: rtl/mt_ckpt_rename_if.sv
// Dispatch, CDB, retire and branch-recovery bundle between the pipeline and the rename map.
interface mt_ckpt_rename_if #(
    parameter int unsigned DISP_W = 2,
    parameter int unsigned CDB_W  = 6,
    parameter int unsigned RET_W  = 2
);
    import mt_pkg::*;

    logic [DISP_W-1:0]      disp_valid;
    logic [DISP_W*AR_W-1:0] disp_dest_ar;
    logic [DISP_W*PR_W-1:0] disp_dest_pr;
    logic [DISP_W*AR_W-1:0] disp_src_a_ar;
    logic [DISP_W*AR_W-1:0] disp_src_b_ar;
    logic [DISP_W*PR_W-1:0] rs_src_a_pr;
    logic [DISP_W-1:0]      rs_src_a_rdy;
    logic [DISP_W*PR_W-1:0] rs_src_b_pr;
    logic [DISP_W-1:0]      rs_src_b_rdy;
    logic [DISP_W*PR_W-1:0] rob_told;
    logic [CDB_W-1:0]       cdb_valid;
    logic [CDB_W*PR_W-1:0]  cdb_pr_tag;
    logic [RET_W-1:0]       ret_valid;
    logic [RET_W*AR_W-1:0]  ret_ar;
    logic [RET_W*PR_W-1:0]  ret_pr;
    logic                   recover;
    logic                   ckpt_take;
    ckpt_id_t               ckpt_id;
    logic                   ckpt_full;
    logic                   br_valid;
    logic                   br_mispredict;
    ckpt_id_t               br_id;

    modport master (
        output disp_valid, disp_dest_ar, disp_dest_pr, disp_src_a_ar, disp_src_b_ar,
        output cdb_valid, cdb_pr_tag, ret_valid, ret_ar, ret_pr,
        output recover, ckpt_take, br_valid, br_mispredict, br_id,
        input  rs_src_a_pr, rs_src_a_rdy, rs_src_b_pr, rs_src_b_rdy, rob_told,
        input  ckpt_id, ckpt_full
    );

    modport slave (
        input  disp_valid, disp_dest_ar, disp_dest_pr, disp_src_a_ar, disp_src_b_ar,
        input  cdb_valid, cdb_pr_tag, ret_valid, ret_ar, ret_pr,
        input  recover, ckpt_take, br_valid, br_mispredict, br_id,
        output rs_src_a_pr, rs_src_a_rdy, rs_src_b_pr, rs_src_b_rdy, rob_told,
        output ckpt_id, ckpt_full
    );
endinterface

// File: rtl/mt_ckpt_rename_ckpt_ctrl.sv
// Checkpoint FIFO bookkeeping: head/tail/count and per-entry resolved bits.
module mt_ckpt_ctrl
    import mt_pkg::*;
(
    input  logic     clock,
    input  logic     reset,
    input  logic     take,
    input  logic     br_valid,
    input  logic     br_mispredict,
    input  ckpt_id_t br_id,
    input  logic     recover,
    output ckpt_id_t ckpt_id,
    output logic     ckpt_full,
    output logic     take_ok
);
    ckpt_id_t            head_q, head_d, tail_q, tail_d, span;
    ckpt_cnt_t           count_q, count_d;
    logic [NUM_CKPT-1:0] done_q, done_d;
    logic                misp, adv;

    assign ckpt_id   = tail_q;
    assign ckpt_full = (count_q == ckpt_cnt_t'(NUM_CKPT));
    assign misp      = br_valid & br_mispredict;
    assign take_ok   = take & ~ckpt_full & ~recover & ~misp;
    assign adv       = (count_q != '0) & done_q[head_q];

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        done_d  = done_q;
        span    = '0;
        if (recover) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            done_d  = '0;
        end else if (misp) begin
            // The mispredicted entry stays live, so an empty span means the FIFO is full.
            tail_d  = ckpt_inc(br_id);
            span    = tail_d - head_q;
            count_d = (span == '0) ? ckpt_cnt_t'(NUM_CKPT) : {1'b0, span};
        end else begin
            if (br_valid) done_d[br_id] = 1'b1;
            if (adv) begin
                done_d[head_q] = 1'b0;
                head_d         = ckpt_inc(head_q);
            end
            if (take_ok) begin
                done_d[tail_q] = 1'b0;
                tail_d         = ckpt_inc(tail_q);
            end
            count_d = count_q + ckpt_cnt_t'(take_ok) - ckpt_cnt_t'(adv);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            done_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: rtl/mt_ckpt_rename.sv
// N-wide rename map with PR ready bits, retirement map and branch checkpoints.
// MT_ZERO_REG_EN: when defined, AR NUM_AR-1 is a hard zero (see mt_pkg).
module mt_ckpt_rename
    import mt_pkg::*;
#(
    parameter int unsigned DISP_W = 2,
    parameter int unsigned CDB_W  = 6,
    parameter int unsigned RET_W  = 2
) (
    input logic             clock,
    input logic             reset,
    mt_ckpt_rename_if.slave bus
);
    logic [PR_W-1:0]   map_q [NUM_AR];
    logic [PR_W-1:0]   map_d [NUM_AR];
    logic [PR_W-1:0]   map_disp [NUM_AR];
    logic [PR_W-1:0]   rrat_q [NUM_AR];
    logic [PR_W-1:0]   rrat_d [NUM_AR];
    logic [PR_W-1:0]   snap_q [NUM_CKPT][NUM_AR];
    logic [PR_W-1:0]   snap_d [NUM_CKPT][NUM_AR];
    logic [NUM_PR-1:0] rdy_q, rdy_d, cdb_set;

    logic [AR_W-1:0] d_da [DISP_W];
    logic [AR_W-1:0] d_sa [DISP_W];
    logic [AR_W-1:0] d_sb [DISP_W];
    logic [PR_W-1:0] d_dpr [DISP_W];
    logic [PR_W-1:0] sa_pr [DISP_W];
    logic [PR_W-1:0] sb_pr [DISP_W];
    logic [PR_W-1:0] told [DISP_W];
    logic            sa_rdy [DISP_W];
    logic            sb_rdy [DISP_W];
    logic [AR_W-1:0] r_ar [RET_W];
    logic [PR_W-1:0] r_pr [RET_W];
    logic            take_ok, misp;

    assign misp = bus.br_valid & bus.br_mispredict;

    for (genvar j = 0; j < DISP_W; j++) begin : g_slot
        assign d_da[j]  = bus.disp_dest_ar[j*AR_W +: AR_W];
        assign d_sa[j]  = bus.disp_src_a_ar[j*AR_W +: AR_W];
        assign d_sb[j]  = bus.disp_src_b_ar[j*AR_W +: AR_W];
        assign d_dpr[j] = bus.disp_dest_pr[j*PR_W +: PR_W];
        assign bus.rs_src_a_pr[j*PR_W +: PR_W] = sa_pr[j];
        assign bus.rs_src_b_pr[j*PR_W +: PR_W] = sb_pr[j];
        assign bus.rob_told[j*PR_W +: PR_W]    = told[j];
        assign bus.rs_src_a_rdy[j]             = sa_rdy[j];
        assign bus.rs_src_b_rdy[j]             = sb_rdy[j];
    end

    for (genvar l = 0; l < RET_W; l++) begin : g_ret
        assign r_ar[l] = bus.ret_ar[l*AR_W +: AR_W];
        assign r_pr[l] = bus.ret_pr[l*PR_W +: PR_W];
    end

    always_comb begin
        cdb_set = '0;
        for (int unsigned l = 0; l < CDB_W; l++)
            if (bus.cdb_valid[l]) cdb_set[bus.cdb_pr_tag[l*PR_W +: PR_W]] = 1'b1;
    end

    // Later slots in the loop overwrite earlier ones, so the youngest older producer wins.
    always_comb begin
        for (int unsigned j = 0; j < DISP_W; j++) begin
            sa_pr[j]  = map_q[d_sa[j]];
            sb_pr[j]  = map_q[d_sb[j]];
            told[j]   = map_q[d_da[j]];
            sa_rdy[j] = rdy_q[sa_pr[j]] | cdb_set[sa_pr[j]] | is_zero_ar(d_sa[j]);
            sb_rdy[j] = rdy_q[sb_pr[j]] | cdb_set[sb_pr[j]] | is_zero_ar(d_sb[j]);
            for (int unsigned k = 0; k < j; k++) begin
                if (bus.disp_valid[k] && d_da[k] == d_sa[j] && !is_zero_ar(d_sa[j])) begin
                    sa_pr[j]  = d_dpr[k];
                    sa_rdy[j] = 1'b0;
                end
                if (bus.disp_valid[k] && d_da[k] == d_sb[j] && !is_zero_ar(d_sb[j])) begin
                    sb_pr[j]  = d_dpr[k];
                    sb_rdy[j] = 1'b0;
                end
                if (bus.disp_valid[k] && d_da[k] == d_da[j]) told[j] = d_dpr[k];
            end
            if (is_zero_ar(d_da[j])) told[j] = d_dpr[j];
        end
    end

    always_comb begin
        map_disp = map_q;
        for (int unsigned k = 0; k < DISP_W; k++)
            if (bus.disp_valid[k] && !is_zero_ar(d_da[k])) map_disp[d_da[k]] = d_dpr[k];

        rrat_d = rrat_q;
        for (int unsigned l = 0; l < RET_W; l++)
            if (bus.ret_valid[l] && !is_zero_ar(r_ar[l])) rrat_d[r_ar[l]] = r_pr[l];

        snap_d = snap_q;
        if (take_ok) snap_d[bus.ckpt_id] = map_disp;

        map_d = map_disp;
        rdy_d = rdy_q | cdb_set;
        if (bus.recover) begin
            map_d = rrat_d;
            rdy_d = '1;
        end else if (misp) begin
            map_d = snap_q[bus.br_id];
        end else begin
            for (int unsigned k = 0; k < DISP_W; k++)
                if (bus.disp_valid[k] && !is_zero_ar(d_da[k])) rdy_d[d_dpr[k]] = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_AR; i++) begin
                map_q[i]  <= PR_W'(i);
                rrat_q[i] <= PR_W'(i);
                for (int unsigned c = 0; c < NUM_CKPT; c++) snap_q[c][i] <= PR_W'(i);
            end
            rdy_q <= '1;
        end else begin
            map_q  <= map_d;
            rrat_q <= rrat_d;
            snap_q <= snap_d;
            rdy_q  <= rdy_d;
        end
    end

    mt_ckpt_ctrl u_ckpt_ctrl (
        .clock         (clock),
        .reset         (reset),
        .take          (bus.ckpt_take),
        .br_valid      (bus.br_valid),
        .br_mispredict (bus.br_mispredict),
        .br_id         (bus.br_id),
        .recover       (bus.recover),
        .ckpt_id       (bus.ckpt_id),
        .ckpt_full     (bus.ckpt_full),
        .take_ok       (take_ok)
    );

    ap_no_take_when_full: assert property (
        @(posedge clock) disable iff (reset) !(bus.ckpt_take && bus.ckpt_full));
endmodule

// File: tb/tb_mt_ckpt_rename.sv
// Scoreboard bench for mt_ckpt_rename: random rename/CDB traffic plus directed checkpoint cases.
module tb_mt_ckpt_rename;
    import mt_pkg::*;

    localparam int unsigned DISP_W = 2;
    localparam int unsigned CDB_W  = 6;
    localparam int unsigned RET_W  = 2;
    localparam int K_SA_PR = 0, K_SA_RDY = 1, K_SB_PR = 2, K_SB_RDY = 3;
    localparam int K_TOLD = 4, K_CK_ID = 5, K_CK_FULL = 6;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mt_ckpt_rename_if #(.DISP_W(DISP_W), .CDB_W(CDB_W), .RET_W(RET_W)) bus ();
    mt_ckpt_rename #(.DISP_W(DISP_W), .CDB_W(CDB_W), .RET_W(RET_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       tag;
        int          kind;
        int          slot;
        logic [31:0] val;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned m_map [NUM_AR];
    bit          m_rdy [NUM_PR];

    task automatic check_val(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(int kind, int slot);
        case (kind)
            K_SA_PR:   return 32'(bus.rs_src_a_pr[slot*PR_W +: PR_W]);
            K_SA_RDY:  return 32'(bus.rs_src_a_rdy[slot]);
            K_SB_PR:   return 32'(bus.rs_src_b_pr[slot*PR_W +: PR_W]);
            K_SB_RDY:  return 32'(bus.rs_src_b_rdy[slot]);
            K_TOLD:    return 32'(bus.rob_told[slot*PR_W +: PR_W]);
            K_CK_ID:   return 32'(bus.ckpt_id);
            K_CK_FULL: return 32'(bus.ckpt_full);
            default:   return 'x;
        endcase
    endfunction

    task automatic expect_out(string tag, int kind, int slot, int val);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.slot = slot;
        e.val  = val;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        #2;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val(e.tag, observe(e.kind, e.slot), e.val);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.disp_valid    = '0;
        bus.disp_dest_ar  = '0;
        bus.disp_dest_pr  = '0;
        bus.disp_src_a_ar = '0;
        bus.disp_src_b_ar = '0;
        bus.cdb_valid     = '0;
        bus.cdb_pr_tag    = '0;
        bus.ret_valid     = '0;
        bus.ret_ar        = '0;
        bus.ret_pr        = '0;
        bus.recover       = 1'b0;
        bus.ckpt_take     = 1'b0;
        bus.br_valid      = 1'b0;
        bus.br_mispredict = 1'b0;
        bus.br_id         = '0;
    endtask

    task automatic slot(int j, int v, int dest, int dpr, int sa, int sb);
        bus.disp_valid[j]                  = (v != 0);
        bus.disp_dest_ar[j*AR_W +: AR_W]   = AR_W'(dest);
        bus.disp_dest_pr[j*PR_W +: PR_W]   = PR_W'(dpr);
        bus.disp_src_a_ar[j*AR_W +: AR_W]  = AR_W'(sa);
        bus.disp_src_b_ar[j*AR_W +: AR_W]  = AR_W'(sb);
    endtask

    task automatic cdb(int l, int tag);
        bus.cdb_valid[l]                 = 1'b1;
        bus.cdb_pr_tag[l*PR_W +: PR_W]   = PR_W'(tag);
    endtask

    task automatic ret(int l, int ar, int pr);
        bus.ret_valid[l]             = 1'b1;
        bus.ret_ar[l*AR_W +: AR_W]   = AR_W'(ar);
        bus.ret_pr[l*PR_W +: PR_W]   = PR_W'(pr);
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        @(posedge clock);
        #1;
        for (int i = 0; i < NUM_AR; i++) m_map[i] = i;
        for (int i = 0; i < NUM_PR; i++) m_rdy[i] = 1'b1;
    endtask

    function automatic int unsigned f_dest(int k);
        return int'(bus.disp_dest_ar[k*AR_W +: AR_W]);
    endfunction

    function automatic int unsigned f_dpr(int k);
        return int'(bus.disp_dest_pr[k*PR_W +: PR_W]);
    endfunction

    function automatic bit cdb_hit(int unsigned pr);
        for (int l = 0; l < CDB_W; l++)
            if (bus.cdb_valid[l] && int'(bus.cdb_pr_tag[l*PR_W +: PR_W]) == pr) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_src(int j, int unsigned ar, output int unsigned pr, output int unsigned rdy);
        pr  = m_map[ar];
        rdy = (m_rdy[pr] || cdb_hit(pr)) ? 1 : 0;
        for (int k = 0; k < j; k++)
            if (bus.disp_valid[k] && f_dest(k) == ar) begin
                pr  = f_dpr(k);
                rdy = 0;
            end
    endtask

    // Expected outputs for the currently driven group, then the state it leaves behind.
    task automatic model_step();
        int unsigned pr, rdy, tpr;
        for (int j = 0; j < DISP_W; j++) begin
            model_src(j, int'(bus.disp_src_a_ar[j*AR_W +: AR_W]), pr, rdy);
            expect_out("rnd_sa_pr", K_SA_PR, j, int'(pr));
            expect_out("rnd_sa_rdy", K_SA_RDY, j, int'(rdy));
            model_src(j, int'(bus.disp_src_b_ar[j*AR_W +: AR_W]), pr, rdy);
            expect_out("rnd_sb_pr", K_SB_PR, j, int'(pr));
            expect_out("rnd_sb_rdy", K_SB_RDY, j, int'(rdy));
            tpr = m_map[f_dest(j)];
            for (int k = 0; k < j; k++)
                if (bus.disp_valid[k] && f_dest(k) == f_dest(j)) tpr = f_dpr(k);
            expect_out("rnd_told", K_TOLD, j, int'(tpr));
        end
        for (int k = 0; k < DISP_W; k++)
            if (bus.disp_valid[k]) m_map[f_dest(k)] = f_dpr(k);
        for (int l = 0; l < CDB_W; l++)
            if (bus.cdb_valid[l]) m_rdy[bus.cdb_pr_tag[l*PR_W +: PR_W]] = 1'b1;
        for (int k = 0; k < DISP_W; k++)
            if (bus.disp_valid[k]) m_rdy[f_dpr(k)] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        #12;
        do_reset();
        expect_out("rst_ckpt_full", K_CK_FULL, 0, 0);
        expect_out("rst_ckpt_id", K_CK_ID, 0, 0);
        tick();

        for (int cyc = 0; cyc < 150; cyc++) begin
            idle();
            for (int j = 0; j < DISP_W; j++)
                slot(j, $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(32, 47),
                     $urandom_range(0, 7), $urandom_range(0, 7));
            for (int l = 0; l < CDB_W; l++)
                if ($urandom_range(0, 1) == 1) cdb(l, $urandom_range(32, 47));
            model_step();
            tick();
        end

        // Reset mid-run
        do_reset();
        slot(0, 0, 7, 0, 5, 5);
        expect_out("t1_sa_pr", K_SA_PR, 0, 5);
        expect_out("t1_sa_rdy", K_SA_RDY, 0, 1);
        expect_out("t1_told", K_TOLD, 0, 7);
        expect_out("t1_full", K_CK_FULL, 0, 0);
        tick();

        // Intra-group bypass and youngest-wins map write
        idle(); slot(0, 1, 3, 40, 0, 0); slot(1, 1, 3, 41, 3, 0);
        expect_out("t2_told0", K_TOLD, 0, 3);
        expect_out("t2_sa1_pr", K_SA_PR, 1, 40);
        expect_out("t2_sa1_rdy", K_SA_RDY, 1, 0);
        expect_out("t2_told1", K_TOLD, 1, 40);
        tick();
        idle(); slot(0, 0, 0, 0, 3, 0); slot(1, 0, 0, 0, 3, 0);
        expect_out("t2_map3_pr", K_SA_PR, 0, 41);
        expect_out("t2_map3_rdy", K_SA_RDY, 0, 0);
        expect_out("t2_nobyp_pr", K_SA_PR, 1, 41);
        tick();

        // CDB same-cycle bypass, then registered ready; dispatch clear beats CDB set
        idle(); slot(0, 1, 9, 40, 0, 0); tick();
        idle(); slot(0, 0, 0, 0, 9, 9);
        expect_out("t3_pre_rdy", K_SA_RDY, 0, 0);
        tick();
        idle(); slot(0, 0, 0, 0, 9, 9); cdb(2, 40);
        expect_out("t3_byp_pr", K_SA_PR, 0, 40);
        expect_out("t3_byp_rdya", K_SA_RDY, 0, 1);
        expect_out("t3_byp_rdyb", K_SB_RDY, 0, 1);
        tick();
        idle(); slot(0, 0, 0, 0, 9, 0);
        expect_out("t3_reg_rdy", K_SA_RDY, 0, 1);
        tick();
        idle(); slot(0, 1, 10, 60, 0, 0); cdb(0, 60); tick();
        idle(); slot(0, 0, 0, 0, 10, 0);
        expect_out("t3_clr_pr", K_SA_PR, 0, 60);
        expect_out("t3_clr_rdy", K_SA_RDY, 0, 0);
        tick();

        // Fill all checkpoints, resolve oldest correctly
        do_reset();
        for (int i = 0; i < int'(NUM_CKPT); i++) begin
            idle(); bus.ckpt_take = 1'b1;
            expect_out("t4_id", K_CK_ID, 0, i);
            expect_out("t4_notfull", K_CK_FULL, 0, 0);
            tick();
        end
        idle(); bus.br_valid = 1'b1; bus.br_id = 2'd0;
        expect_out("t4_full", K_CK_FULL, 0, 1);
        expect_out("t4_wrap_id", K_CK_ID, 0, 0);
        tick();
        idle(); expect_out("t4_full_hold", K_CK_FULL, 0, 1); tick();
        idle(); expect_out("t4_freed", K_CK_FULL, 0, 0); tick();

        // Mispredict restores snapshot and frees younger checkpoints
        do_reset();
        idle(); bus.ckpt_take = 1'b1; expect_out("t5_id0", K_CK_ID, 0, 0); tick();
        idle(); slot(0, 1, 3, 50, 0, 0); bus.ckpt_take = 1'b1;
        expect_out("t5_id1", K_CK_ID, 0, 1);
        tick();
        idle(); slot(0, 1, 3, 60, 0, 0); tick();
        idle(); slot(0, 0, 0, 0, 3, 0); bus.ckpt_take = 1'b1;
        expect_out("t5_pre_pr", K_SA_PR, 0, 60);
        expect_out("t5_id2", K_CK_ID, 0, 2);
        tick();
        idle(); bus.br_valid = 1'b1; bus.br_mispredict = 1'b1; bus.br_id = 2'd1;
        slot(0, 1, 3, 70, 0, 0); bus.ckpt_take = 1'b1;
        expect_out("t5_id3", K_CK_ID, 0, 3);
        tick();
        idle(); slot(0, 0, 0, 0, 3, 0); bus.ckpt_take = 1'b1;
        expect_out("t5_restored_pr", K_SA_PR, 0, 50);
        expect_out("t5_restored_rdy", K_SA_RDY, 0, 0);
        expect_out("t5_tail", K_CK_ID, 0, 2);
        expect_out("t5_notfull", K_CK_FULL, 0, 0);
        tick();
        idle(); bus.ckpt_take = 1'b1;
        expect_out("t5_id3b", K_CK_ID, 0, 3);
        expect_out("t5_notfull2", K_CK_FULL, 0, 0);
        tick();
        idle(); expect_out("t5_full", K_CK_FULL, 0, 1); tick();

        // Full flush with same-cycle retires
        do_reset();
        idle(); slot(0, 1, 3, 55, 0, 0); ret(0, 5, 77); bus.ckpt_take = 1'b1; tick();
        idle(); bus.recover = 1'b1; ret(0, 3, 44); ret(1, 3, 50);
        slot(0, 1, 4, 66, 0, 0); bus.ckpt_take = 1'b1;
        tick();
        idle(); slot(0, 0, 0, 0, 3, 5); slot(1, 0, 0, 0, 4, 0);
        expect_out("t6_map3", K_SA_PR, 0, 50);
        expect_out("t6_rdy50", K_SA_RDY, 0, 1);
        expect_out("t6_map5", K_SB_PR, 0, 77);
        expect_out("t6_rdy77", K_SB_RDY, 0, 1);
        expect_out("t6_map4", K_SA_PR, 1, 4);
        expect_out("t6_id", K_CK_ID, 0, 0);
        expect_out("t6_notfull", K_CK_FULL, 0, 0);
        tick();
        for (int i = 0; i < int'(NUM_CKPT); i++) begin
            idle(); bus.ckpt_take = 1'b1;
            expect_out("t6_cnt_notfull", K_CK_FULL, 0, 0);
            tick();
        end
        idle(); expect_out("t6_cnt_full", K_CK_FULL, 0, 1); tick();

        // Top architectural register
        do_reset();
        idle(); slot(0, 1, 31, 90, 0, 0); slot(1, 0, 0, 0, 31, 0);
`ifdef MT_ZERO_REG_EN
        expect_out("t6z_told", K_TOLD, 0, 90);
        expect_out("t6z_src_pr", K_SA_PR, 1, 31);
        expect_out("t6z_src_rdy", K_SA_RDY, 1, 1);
`else
        expect_out("t6z_told", K_TOLD, 0, 31);
        expect_out("t6z_src_pr", K_SA_PR, 1, 90);
        expect_out("t6z_src_rdy", K_SA_RDY, 1, 0);
`endif
        tick();
        idle(); slot(0, 0, 0, 0, 31, 0);
`ifdef MT_ZERO_REG_EN
        expect_out("t6z_map_pr", K_SA_PR, 0, 31);
        expect_out("t6z_map_rdy", K_SA_RDY, 0, 1);
`else
        expect_out("t6z_map_pr", K_SA_PR, 0, 90);
        expect_out("t6z_map_rdy", K_SA_RDY, 0, 0);
`endif
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
